// File: rtl/flush_reclaim_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flush_reclaim_seq_pkg
//  Description : Shared types and sizing constants for flush_reclaim_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
package flush_reclaim_seq_pkg;

    localparam int ROB_SIZE = 16;
    localparam int PREG_W   = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } reclaim_state_t;

endpackage
`default_nettype wire

// File: rtl/flush_reclaim_seq.sv
`default_nettype none
// ============================================================================
//  Module      : flush_reclaim_seq
//  Description : Captures squashed pregs on a flush and drains them two per
//                cycle into the free list; passes commit frees through in idle.
//                Optional macro FLUSH_RECLAIM_PERF_EN adds perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module flush_reclaim_seq #(
    parameter int PREG_W   = flush_reclaim_seq_pkg::PREG_W,
    parameter int ROB_SIZE = flush_reclaim_seq_pkg::ROB_SIZE,
    parameter int CNT_W    = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             commit_free,
    input  logic [PREG_W-1:0]                commit_preg,
    input  logic                             commit_free_1,
    input  logic [PREG_W-1:0]                commit_preg_1,
    input  logic                             flush_req,
    input  logic [CNT_W-1:0]                 flush_count,
    input  logic [ROB_SIZE-1:0][PREG_W-1:0]  flush_pregs,
    input  logic                             fl_full,
    output logic                             fl_free,
    output logic [PREG_W-1:0]                fl_free_preg,
    output logic                             fl_free_1,
    output logic [PREG_W-1:0]                fl_free_preg_1,
    output logic                             busy
`ifdef FLUSH_RECLAIM_PERF_EN
    ,
    output logic [31:0]                      perf_drain_cycles,
    output logic [31:0]                      perf_reclaimed
`endif
);

    import flush_reclaim_seq_pkg::*;

    localparam int IDX_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

    reclaim_state_t    r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_rem, w_rem_nxt;
    logic [CNT_W-1:0]  r_idx, w_idx_nxt;
    logic [PREG_W-1:0] r_buf [ROB_SIZE];
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_idx_p1;
    logic              w_capture;
    logic [1:0]        w_emit;

    // Illegal oversize counts are clamped so the drain never walks off the buffer.
    assign w_count   = (flush_count > CNT_W'(ROB_SIZE)) ? CNT_W'(ROB_SIZE) : flush_count;
    assign w_idx_p1  = r_idx + CNT_W'(1);
    assign w_capture = (r_state == IDLE) && flush_req && (w_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (CNT_W'(i) < w_count) r_buf[i] <= flush_pregs[i];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_idx_nxt      = r_idx;
        w_emit         = 2'd0;
        fl_free        = 1'b0;
        fl_free_preg   = '0;
        fl_free_1      = 1'b0;
        fl_free_preg_1 = '0;
        busy           = 1'b0;
        case (r_state)
            IDLE: begin
                // Commit frees are older than the flushed pregs, so they go first.
                fl_free        = commit_free;
                fl_free_preg   = commit_preg;
                fl_free_1      = commit_free_1;
                fl_free_preg_1 = commit_preg_1;
                if (w_capture) begin
                    w_state_nxt = DRAIN;
                    w_rem_nxt   = w_count;
                    w_idx_nxt   = '0;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (!fl_full) begin
                    if (r_rem >= CNT_W'(2)) begin
                        fl_free        = 1'b1;
                        fl_free_preg   = r_buf[r_idx[IDX_W-1:0]];
                        fl_free_1      = 1'b1;
                        fl_free_preg_1 = r_buf[w_idx_p1[IDX_W-1:0]];
                        w_idx_nxt      = r_idx + CNT_W'(2);
                        w_rem_nxt      = r_rem - CNT_W'(2);
                        w_emit         = 2'd2;
                    end else if (r_rem == CNT_W'(1)) begin
                        fl_free      = 1'b1;
                        fl_free_preg = r_buf[r_idx[IDX_W-1:0]];
                        w_rem_nxt    = '0;
                        w_emit       = 2'd1;
                    end
                end
                if (w_rem_nxt == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (rst) begin
            fl_free        = 1'b0;
            fl_free_preg   = '0;
            fl_free_1      = 1'b0;
            fl_free_preg_1 = '0;
            busy           = 1'b0;
            w_emit         = 2'd0;
        end
    end

`ifdef FLUSH_RECLAIM_PERF_EN
    logic [32:0] w_rec_sum;
    assign w_rec_sum = {1'b0, perf_reclaimed} + 33'(w_emit);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_drain_cycles <= '0;
            perf_reclaimed    <= '0;
        end else begin
            if (r_state == DRAIN && perf_drain_cycles != '1)
                perf_drain_cycles <= perf_drain_cycles + 32'd1;
            perf_reclaimed <= w_rec_sum[32] ? '1 : w_rec_sum[31:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_state != DRAIN || (!commit_free && !commit_free_1));
            assert (r_state != DRAIN || !flush_req);
            assert (!flush_req || flush_count <= CNT_W'(ROB_SIZE));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flush_reclaim_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flush_reclaim_seq
//  Description : Directed table-driven bench for flush_reclaim_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flush_reclaim_seq;

    logic             clk = 1'b0;
    logic             rst;
    logic             commit_free, commit_free_1;
    logic [5:0]       commit_preg, commit_preg_1;
    logic             flush_req;
    logic [4:0]       flush_count;
    logic [15:0][5:0] flush_pregs;
    logic             fl_full;
    logic             fl_free, fl_free_1, busy;
    logic [5:0]       fl_free_preg, fl_free_preg_1;
`ifdef FLUSH_RECLAIM_PERF_EN
    logic [31:0]      perf_drain_cycles, perf_reclaimed;
`endif

    always #5 clk = ~clk;

    flush_reclaim_seq dut (
        .clk            (clk),
        .rst            (rst),
        .commit_free    (commit_free),
        .commit_preg    (commit_preg),
        .commit_free_1  (commit_free_1),
        .commit_preg_1  (commit_preg_1),
        .flush_req      (flush_req),
        .flush_count    (flush_count),
        .flush_pregs    (flush_pregs),
        .fl_full        (fl_full),
        .fl_free        (fl_free),
        .fl_free_preg   (fl_free_preg),
        .fl_free_1      (fl_free_1),
        .fl_free_preg_1 (fl_free_preg_1),
        .busy           (busy)
`ifdef FLUSH_RECLAIM_PERF_EN
        ,
        .perf_drain_cycles (perf_drain_cycles),
        .perf_reclaimed    (perf_reclaimed)
`endif
    );

    typedef struct {
        logic       rst;
        logic       cf;
        logic [5:0] cp;
        logic       cf1;
        logic [5:0] cp1;
        logic       fr;
        logic [4:0] fc;
        logic       full;
        logic       e_f;
        logic [5:0] e_p;
        logic       e_f1;
        logic [5:0] e_p1;
        logic       e_busy;
    } vec_t;

    vec_t vecs [64];
    int   n_rows = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic cf, input logic [5:0] cp,
                       input logic cf1, input logic [5:0] cp1, input logic fr,
                       input logic [4:0] fc, input logic full, input logic ef,
                       input logic [5:0] ep, input logic ef1, input logic [5:0] ep1,
                       input logic eb);
        vecs[n_rows] = '{r, cf, cp, cf1, cp1, fr, fc, full, ef, ep, ef1, ep1, eb};
        n_rows++;
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
        end
    endtask

    task automatic check_outs(input int row, input logic ef, input logic [5:0] ep,
                              input logic ef1, input logic [5:0] ep1, input logic eb);
        chk("fl_free", row, 32'(fl_free), 32'(ef));
        chk("fl_free_1", row, 32'(fl_free_1), 32'(ef1));
        chk("busy", row, 32'(busy), 32'(eb));
        if (ef)  chk("fl_free_preg", row, 32'(fl_free_preg), 32'(ep));
        if (ef1) chk("fl_free_preg_1", row, 32'(fl_free_preg_1), 32'(ep1));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; commit_free = 1'b0; commit_preg = '0; commit_free_1 = 1'b0;
        commit_preg_1 = '0; flush_req = 1'b0; flush_count = '0; fl_full = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) flush_pregs[i] = 6'(33 + i);
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // reset state, then commit passthrough
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0);
        add(0,1,40,1,41,0,0,0, 1,40,1,41,0);
        // five-entry flush: pairs then a lone last entry
        add(0,0,0,0,0,1,5,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0,0, 1,33,1,34,1);
        add(0,0,0,0,0,0,0,0, 1,35,1,36,1);
        add(0,0,0,0,0,0,0,0, 1,37,0,0,1);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0);
        // zero-count flush with concurrent commits
        add(0,1,20,1,21,1,0,0, 1,20,1,21,0);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0);
        // four-entry flush with commit in same cycle, then a full stall
        add(0,1,5,1,6,1,4,0, 1,5,1,6,0);
        add(0,0,0,0,0,0,0,1, 0,0,0,0,1);
        add(0,0,0,0,0,0,0,0, 1,33,1,34,1);
        add(0,0,0,0,0,0,0,0, 1,35,1,36,1);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0);
        // single-entry flush
        add(0,0,0,0,0,1,1,0, 0,0,0,0,0);
        add(0,0,0,0,0,0,0,0, 1,33,0,0,1);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0);
        // clear counters, then a full-buffer flush
        add(1,0,0,0,0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0,0,1,16,0, 0,0,0,0,0);
        for (int k = 0; k < 8; k++)
            add(0,0,0,0,0,0,0,0, 1,6'(33+2*k),1,6'(34+2*k),1);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0);

        for (int r = 0; r < n_rows; r++) begin
            @(posedge clk);
            #1;
            rst = vecs[r].rst; commit_free = vecs[r].cf; commit_preg = vecs[r].cp;
            commit_free_1 = vecs[r].cf1; commit_preg_1 = vecs[r].cp1;
            flush_req = vecs[r].fr; flush_count = vecs[r].fc; fl_full = vecs[r].full;
            #1;
            check_outs(r, vecs[r].e_f, vecs[r].e_p, vecs[r].e_f1, vecs[r].e_p1, vecs[r].e_busy);
        end

`ifdef FLUSH_RECLAIM_PERF_EN
        chk("perf_drain_cycles", n_rows, perf_drain_cycles, 32'd8);
        chk("perf_reclaimed", n_rows, perf_reclaimed, 32'd16);
`endif

        // reset in the middle of an eight-entry drain
        @(posedge clk); #1;
        idle_inputs(); flush_req = 1'b1; flush_count = 5'd8;
        @(posedge clk); #1;
        idle_inputs(); #1;
        check_outs(100, 1'b1, 6'd33, 1'b1, 6'd34, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        check_outs(101, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            check_outs(102 + k, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        end
        // passthrough works again after the abandoned drain
        commit_free = 1'b1; commit_preg = 6'd12; #1;
        check_outs(110, 1'b1, 6'd12, 1'b0, 6'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
